// File: rtl/rv_sync_fifo.sv
// Ready/valid first-word-fall-through FIFO between the register slices and the slave stage.
// m_ready and s_valid come only from registered pointers, so no combinational path crosses it.
module rv_sync_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AF_LEVEL = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_valid,
  input  logic [WIDTH-1:0]         m_data,
  output logic                     m_ready,
  output logic                     s_valid,
  output logic [WIDTH-1:0]         s_data,
  input  logic                     s_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] AfLevel = (AW+1)'(AF_LEVEL);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_addr, rd_addr;
  logic          empty, full;
  logic          push, pop;

  assign wr_addr = wr_ptr_q[AW-1:0];
  assign rd_addr = rd_ptr_q[AW-1:0];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_addr == rd_addr) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign m_ready = !full;
  assign s_valid = !empty;

  assign push = m_valid && m_ready;
  assign pop  = s_valid && s_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; a beat arriving during reset is dropped.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_addr] <= m_data;
    end
  end

  assign s_data      = s_valid ? mem[rd_addr] : '0;
  assign count       = count_q;
  assign almost_full = (count_q >= AfLevel);

endmodule
